// File: rtl/channel_row_accumulator.sv
// Per-lane row accumulator: pops a row length, then sums that many signed products with
// saturation and hands the row sum downstream over a valid/ready pair.
module channel_row_accumulator #(
  parameter int unsigned channel_num = 4,
  parameter int unsigned val_bits    = 8,
  parameter int unsigned acc_bits    = 32,
  parameter int unsigned len_bits    = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [val_bits*2*channel_num-1:0] mult,
  input  logic [channel_num-1:0]          mult_fifo_empty,
  output logic [channel_num-1:0]          mult_fifo_read,
  input  logic [len_bits*channel_num-1:0] rowlen,
  input  logic [channel_num-1:0]          rowlen_fifo_empty,
  output logic [channel_num-1:0]          rowlen_fifo_read,
  output logic [acc_bits*channel_num-1:0] res,
  output logic [channel_num-1:0]          res_valid,
  input  logic [channel_num-1:0]          res_ready,
  output logic [channel_num-1:0]          ovf
);

  localparam int unsigned ProdBits = 2 * val_bits;

  typedef enum logic [1:0] {StIdle, StLoad, StAcc, StOut} state_e;

  for (genvar i = 0; i < channel_num; i++) begin : g_lane
    state_e                     state_q, state_d;
    logic [len_bits-1:0]        len_q, len_d;
    logic [len_bits-1:0]        issued_q, issued_d;
    logic [len_bits-1:0]        recv_q, recv_d;
    logic signed [acc_bits-1:0] acc_q, acc_d;
    logic                       rd_pend_q, rd_pend_d;
    logic                       ovf_q, ovf_d;

    logic [ProdBits-1:0]        prod;
    logic [len_bits-1:0]        row_len;
    logic [len_bits:0]          recv_inc;
    logic [acc_bits:0]          sum;
    logic [acc_bits-1:0]        sum_sat;
    logic                       sum_ovf;
    logic                       m_rd, rl_rd, valid;

    assign prod     = mult[i*ProdBits +: ProdBits];
    assign row_len  = rowlen[i*len_bits +: len_bits];
    assign recv_inc = {1'b0, recv_q} + {{len_bits{1'b0}}, 1'b1};

    // One guard bit: overflow shows up as the top two bits disagreeing.
    assign sum = {acc_q[acc_bits-1], acc_q}
               + {{(acc_bits+1-ProdBits){prod[ProdBits-1]}}, prod};
    assign sum_ovf = sum[acc_bits] ^ sum[acc_bits-1];

    always_comb begin
      sum_sat = sum[acc_bits-1:0];
      if (sum_ovf) begin
        sum_sat = sum[acc_bits] ? {1'b1, {(acc_bits-1){1'b0}}} : {1'b0, {(acc_bits-1){1'b1}}};
      end
    end

    always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      issued_d = issued_q;
      recv_d   = recv_q;
      acc_d    = acc_q;
      ovf_d    = ovf_q;
      m_rd     = 1'b0;
      rl_rd    = 1'b0;
      valid    = 1'b0;
      case (state_q)
        StIdle: begin
          if (!rowlen_fifo_empty[i]) begin
            rl_rd   = 1'b1;
            state_d = StLoad;
          end
        end
        StLoad: begin
          len_d    = row_len;
          acc_d    = '0;
          issued_d = '0;
          recv_d   = '0;
          state_d  = (row_len == '0) ? StOut : StAcc;
        end
        StAcc: begin
          m_rd = !mult_fifo_empty[i] && (issued_q < len_q);
          if (m_rd) begin
            issued_d = issued_q + len_bits'(1);
          end
          // Product popped last cycle is on the bus now.
          if (rd_pend_q) begin
            acc_d  = sum_sat;
            ovf_d  = ovf_q | sum_ovf;
            recv_d = recv_inc[len_bits-1:0];
            if (recv_inc == {1'b0, len_q}) begin
              state_d = StOut;
            end
          end
        end
        StOut: begin
          valid = 1'b1;
          if (res_ready[i]) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
      if (rst) begin
        m_rd  = 1'b0;
        rl_rd = 1'b0;
      end
      rd_pend_d = m_rd;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q   <= StIdle;
        len_q     <= '0;
        issued_q  <= '0;
        recv_q    <= '0;
        acc_q     <= '0;
        rd_pend_q <= 1'b0;
        ovf_q     <= 1'b0;
      end else begin
        state_q   <= state_d;
        len_q     <= len_d;
        issued_q  <= issued_d;
        recv_q    <= recv_d;
        acc_q     <= acc_d;
        rd_pend_q <= rd_pend_d;
        ovf_q     <= ovf_d;
      end
    end

    assign mult_fifo_read[i]            = m_rd;
    assign rowlen_fifo_read[i]          = rl_rd;
    assign res_valid[i]                 = valid;
    assign res[i*acc_bits +: acc_bits]  = acc_q;
    assign ovf[i]                       = ovf_q;
  end

endmodule

// File: tb/tb_channel_row_accumulator.sv
// Directed bench: two instances (32-bit and 16-bit accumulators) share one behavioural
// model of the product and row-length FIFOs, driven by the 32-bit instance's reads.
module tb_channel_row_accumulator;
  localparam int CH = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [63:0]  mult;
  logic [3:0]   m_empty, m_rd_a, m_rd_b;
  logic [63:0]  rowlen;
  logic [3:0]   r_empty, r_rd_a, r_rd_b;
  logic [127:0] res_a;
  logic [63:0]  res_b;
  logic [3:0]   v_a, v_b, ready, ovf_a, ovf_b;
  logic [3:0]   force_m;

  channel_row_accumulator #(.channel_num(4), .val_bits(8), .acc_bits(32), .len_bits(16)) u_a (
    .clk(clk), .rst(rst), .mult(mult), .mult_fifo_empty(m_empty), .mult_fifo_read(m_rd_a),
    .rowlen(rowlen), .rowlen_fifo_empty(r_empty), .rowlen_fifo_read(r_rd_a), .res(res_a),
    .res_valid(v_a), .res_ready(ready), .ovf(ovf_a)
  );

  channel_row_accumulator #(.channel_num(4), .val_bits(8), .acc_bits(16), .len_bits(16)) u_b (
    .clk(clk), .rst(rst), .mult(mult), .mult_fifo_empty(m_empty), .mult_fifo_read(m_rd_b),
    .rowlen(rowlen), .rowlen_fifo_empty(r_empty), .rowlen_fifo_read(r_rd_b), .res(res_b),
    .res_valid(v_b), .res_ready(ready), .ovf(ovf_b)
  );

  // FIFO model storage: pointers grow monotonically, storage index wraps mod 32.
  logic [15:0] mq [CH][32];
  logic [15:0] rq [CH][32];
  int          mh [CH] = '{default: 0};
  int          mt [CH] = '{default: 0};
  int          rh [CH] = '{default: 0};
  int          rt [CH] = '{default: 0};
  logic [15:0] mdout [CH] = '{default: '0};
  logic [15:0] rdout [CH] = '{default: '0};
  int          bad_pop = 0;
  int          rd_diff = 0;

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      m_empty[i]         = (mh[i] == mt[i]) || force_m[i];
      r_empty[i]         = (rh[i] == rt[i]);
      mult[i*16 +: 16]   = mdout[i];
      rowlen[i*16 +: 16] = rdout[i];
    end
  end

  always @(posedge clk) begin
    if (m_rd_a !== m_rd_b || r_rd_a !== r_rd_b) rd_diff++;
    for (int i = 0; i < CH; i++) begin
      if (m_rd_a[i]) begin
        if (m_empty[i]) bad_pop++;
        else begin
          mdout[i] <= mq[i][mh[i] % 32];
          mh[i]    <= mh[i] + 1;
        end
      end
      if (r_rd_a[i]) begin
        if (r_empty[i]) bad_pop++;
        else begin
          rdout[i] <= rq[i][rh[i] % 32];
          rh[i]    <= rh[i] + 1;
        end
      end
      if (rst) begin
        mh[i] <= mt[i];
        rh[i] <= rt[i];
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] rd_pat, rr_pat, v_pat;
  logic [3:0]  other_v;
  logic [31:0] res_x, res_y;
  logic [15:0] resb_x, resb_y;
  logic        ovfb_x, ovfb_y, ovfb_z;
  int          bad0, diff0;

  task automatic push_m(input int ln, input logic [15:0] v);
    mq[ln][mt[ln] % 32] = v;
    mt[ln] = mt[ln] + 1;
  endtask

  task automatic push_r(input int ln, input logic [15:0] v);
    rq[ln][rt[ln] % 32] = v;
    rt[ln] = rt[ln] + 1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rec;
    rd_pat = '0; rr_pat = '0; v_pat = '0; other_v = '0;
  endtask

  task automatic rec(input int k, input int ln);
    rd_pat[k] = m_rd_a[ln];
    rr_pat[k] = r_rd_a[ln];
    v_pat[k]  = v_a[ln];
  endtask

  task automatic test_reset;
    rst = 1'b1; ready = '0; force_m = '0;
    tick; tick; tick;
    rst = 1'b0;
    #1;
    n_cmp++; if (v_a !== 4'h0) begin n_bad++; $display("FAIL reset_valid: got %h want 0", v_a); end
    n_cmp++; if (res_a !== '0) begin n_bad++; $display("FAIL reset_res: got %h want 0", res_a); end
    n_cmp++; if (ovf_a !== 4'h0 || ovf_b !== 4'h0) begin
      n_bad++; $display("FAIL reset_ovf: got %h/%h want 0", ovf_a, ovf_b); end
    n_cmp++; if (m_rd_a !== 4'h0 || r_rd_a !== 4'h0) begin
      n_bad++; $display("FAIL reset_reads: got %h/%h want 0", m_rd_a, r_rd_a); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    ready = 4'hF;
    push_m(0, 16'd5); push_m(0, 16'hFFFE); push_m(0, 16'd7); push_r(0, 16'd3);
    clear_rec;
    for (int k = 0; k < 8; k++) begin
      #1;
      rec(k, 0);
      other_v |= v_a[3:1];
      if (k == 6) begin res_x = res_a[31:0]; resb_x = res_b[15:0]; end
      @(posedge clk); #1;
    end
    n_cmp++; if (rr_pat[7:0] !== 8'h01) begin n_bad++; $display("FAIL basic_rowlen_pop: got %b want 00000001", rr_pat[7:0]); end
    n_cmp++; if (rd_pat[7:0] !== 8'b0001_1100) begin n_bad++; $display("FAIL basic_mult_pop: got %b want 00011100", rd_pat[7:0]); end
    n_cmp++; if (v_pat[7:0] !== 8'b0100_0000) begin n_bad++; $display("FAIL basic_valid: got %b want 01000000", v_pat[7:0]); end
    n_cmp++; if (res_x !== 32'd10) begin n_bad++; $display("FAIL basic_res: got %0d want 10", res_x); end
    n_cmp++; if (resb_x !== 16'd10) begin n_bad++; $display("FAIL basic_res16: got %0d want 10", resb_x); end
    n_cmp++; if (other_v !== 3'b000) begin n_bad++; $display("FAIL basic_other_lanes: got %b want 000", other_v); end
  endtask

  task automatic test_zero_len;
    push_r(0, 16'd0); push_r(0, 16'd0);
    clear_rec;
    for (int k = 0; k < 8; k++) begin
      #1;
      rec(k, 0);
      if (k == 2) res_x = res_a[31:0];
      @(posedge clk); #1;
    end
    n_cmp++; if (rr_pat[7:0] !== 8'b0000_1001) begin n_bad++; $display("FAIL zero_rowlen_pop: got %b want 00001001", rr_pat[7:0]); end
    n_cmp++; if (rd_pat[7:0] !== 8'h00) begin n_bad++; $display("FAIL zero_mult_pop: got %b want 0", rd_pat[7:0]); end
    n_cmp++; if (v_pat[7:0] !== 8'b0010_0100) begin n_bad++; $display("FAIL zero_valid: got %b want 00100100", v_pat[7:0]); end
    n_cmp++; if (res_x !== 32'd0) begin n_bad++; $display("FAIL zero_res: got %0d want 0", res_x); end
  endtask

  task automatic test_empty_bubbles;
    bad0 = bad_pop;
    push_m(0, 16'd1); push_m(0, 16'd2); push_m(0, 16'd3); push_m(0, 16'd4); push_r(0, 16'd4);
    clear_rec;
    for (int k = 0; k < 14; k++) begin
      force_m[0] = (k % 2 == 0);
      #1;
      rec(k, 0);
      if (k == 11) res_x = res_a[31:0];
      @(posedge clk); #1;
    end
    force_m = '0;
    n_cmp++; if ($countones(rd_pat[13:0]) != 4) begin n_bad++; $display("FAIL bubble_pop_count: got %0d want 4", $countones(rd_pat[13:0])); end
    n_cmp++; if (rd_pat[13:0] !== 14'b00_0010_1010_1000) begin n_bad++; $display("FAIL bubble_pop_cycles: got %b want 00001010101000", rd_pat[13:0]); end
    n_cmp++; if (bad_pop != bad0) begin n_bad++; $display("FAIL bubble_pop_while_empty: got %0d want 0", bad_pop - bad0); end
    n_cmp++; if (v_pat[13:0] !== 14'b00_1000_0000_0000) begin n_bad++; $display("FAIL bubble_valid: got %b want 00100000000000", v_pat[13:0]); end
    n_cmp++; if (res_x !== 32'd10) begin n_bad++; $display("FAIL bubble_res: got %0d want 10", res_x); end
  endtask

  task automatic test_back_to_back;
    push_m(0, 16'd6); push_m(0, 16'd7); push_m(0, 16'd100); push_r(0, 16'd2); push_r(0, 16'd1);
    clear_rec;
    for (int k = 0; k < 17; k++) begin
      ready[0] = (k >= 10);
      #1;
      rec(k, 0);
      if (k >= 5 && k <= 9) begin
        n_cmp++; if (res_a[31:0] !== 32'd13) begin n_bad++; $display("FAIL hold_res_k%0d: got %0d want 13", k, res_a[31:0]); end
      end
      if (k == 15) res_x = res_a[31:0];
      @(posedge clk); #1;
    end
    ready[0] = 1'b1;
    n_cmp++; if (v_pat[16:0] !== 17'h087E0) begin n_bad++; $display("FAIL hold_valid: got %h want 087e0", v_pat[16:0]); end
    n_cmp++; if (rr_pat[16:0] !== 17'h00801) begin n_bad++; $display("FAIL hold_rowlen_pop: got %h want 00801", rr_pat[16:0]); end
    n_cmp++; if (rd_pat[16:0] !== 17'h0200C) begin n_bad++; $display("FAIL hold_mult_pop: got %h want 0200c", rd_pat[16:0]); end
    n_cmp++; if (res_x !== 32'd100) begin n_bad++; $display("FAIL hold_next_res: got %0d want 100", res_x); end
  endtask

  task automatic test_saturation;
    diff0 = rd_diff;
    push_m(0, 16'h7FFF); push_m(0, 16'd1); push_m(0, 16'hFFFB); push_m(0, 16'd2);
    push_r(0, 16'd3); push_r(0, 16'd1);
    clear_rec;
    for (int k = 0; k < 13; k++) begin
      #1;
      rec(k, 0);
      if (k == 3) ovfb_x = ovf_b[0];
      if (k == 6) begin res_x = res_a[31:0]; resb_x = res_b[15:0]; ovfb_y = ovf_b[0]; end
      if (k == 11) begin resb_y = res_b[15:0]; ovfb_z = ovf_b[0]; res_y = res_a[31:0]; end
      @(posedge clk); #1;
    end
    n_cmp++; if (v_pat[12:0] !== 13'h0840) begin n_bad++; $display("FAIL sat_valid: got %h want 0840", v_pat[12:0]); end
    n_cmp++; if (ovfb_x !== 1'b0) begin n_bad++; $display("FAIL sat_ovf_before: got %b want 0", ovfb_x); end
    n_cmp++; if (resb_x !== 16'h7FFA) begin n_bad++; $display("FAIL sat_res16: got %h want 7ffa", resb_x); end
    n_cmp++; if (ovfb_y !== 1'b1) begin n_bad++; $display("FAIL sat_ovf16: got %b want 1", ovfb_y); end
    n_cmp++; if (res_x !== 32'd32763) begin n_bad++; $display("FAIL sat_res32: got %0d want 32763", res_x); end
    n_cmp++; if (resb_y !== 16'd2) begin n_bad++; $display("FAIL sat_next_res16: got %0d want 2", resb_y); end
    n_cmp++; if (ovfb_z !== 1'b1) begin n_bad++; $display("FAIL sat_ovf_sticky: got %b want 1", ovfb_z); end
    n_cmp++; if (ovf_a !== 4'h0) begin n_bad++; $display("FAIL sat_ovf32: got %h want 0", ovf_a); end
    n_cmp++; if (res_y !== 32'd2) begin n_bad++; $display("FAIL sat_next_res32: got %0d want 2", res_y); end
    n_cmp++; if (rd_diff != diff0) begin n_bad++; $display("FAIL sat_read_match: got %0d want 0", rd_diff - diff0); end
  endtask

  task automatic test_mid_reset;
    push_r(2, 16'd5); push_m(2, 16'd3); push_m(2, 16'd4);
    clear_rec;
    for (int k = 0; k < 6; k++) begin
      #1;
      rec(k, 2);
      @(posedge clk); #1;
    end
    n_cmp++; if (rd_pat[5:0] !== 6'b00_1100) begin n_bad++; $display("FAIL midrst_pops: got %b want 001100", rd_pat[5:0]); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    n_cmp++; if (res_a !== '0 || res_b !== '0) begin n_bad++; $display("FAIL midrst_res: got %h/%h want 0", res_a, res_b); end
    n_cmp++; if (v_a !== 4'h0 || v_b !== 4'h0) begin n_bad++; $display("FAIL midrst_valid: got %h/%h want 0", v_a, v_b); end
    n_cmp++; if (ovf_a !== 4'h0 || ovf_b !== 4'h0) begin n_bad++; $display("FAIL midrst_ovf: got %h/%h want 0", ovf_a, ovf_b); end
    n_cmp++; if (m_rd_a !== 4'h0 || r_rd_a !== 4'h0) begin n_bad++; $display("FAIL midrst_reads: got %h/%h want 0", m_rd_a, r_rd_a); end
    @(posedge clk); #1;
    push_r(2, 16'd2); push_m(2, 16'd3); push_m(2, 16'd4);
    clear_rec;
    for (int k = 0; k < 7; k++) begin
      #1;
      rec(k, 2);
      if (k == 5) res_x = res_a[95:64];
      @(posedge clk); #1;
    end
    n_cmp++; if (v_pat[6:0] !== 7'b010_0000) begin n_bad++; $display("FAIL midrst_next_valid: got %b want 0100000", v_pat[6:0]); end
    n_cmp++; if (res_x !== 32'd7) begin n_bad++; $display("FAIL midrst_next_res: got %0d want 7", res_x); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_zero_len;
    test_empty_bubbles;
    test_back_to_back;
    test_saturation;
    test_mid_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
